// File: rtl/stream_sq_pkg.sv
// Shared types and constants for the streaming square stage.
package stream_sq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int MODE_EACH = 0;
    localparam int MODE_SUM  = 1;

endpackage

// File: rtl/ap_chain_ctl.sv
// Block-level ap_ctrl_chain handshake: start gating and propagation, done latching.
// Reusable by any dataflow process that reports its own idle state and final handshake.
module ap_chain_ctl (
    input  logic ap_clk,
    input  logic ap_rst_n,
    input  logic ap_start,
    input  logic start_full_n,
    input  logic ap_continue,
    input  logic proc_idle,
    input  logic last_hs,
    output logic real_start,
    output logic start_write,
    output logic start_accept,
    output logic ap_done,
    output logic ap_ready,
    output logic ap_idle
);

    logic start_once_reg;
    logic ap_done_reg;

    // A start is only real once the downstream start FIFO can take our token.
    assign real_start  = (!start_once_reg && !start_full_n) ? 1'b0 : ap_start;
    assign start_write = !start_once_reg && real_start;
    assign ap_ready    = last_hs;
    assign ap_done     = last_hs || ap_done_reg;
    assign ap_idle     = proc_idle && !real_start;
    // An unacknowledged done blocks a new start, unless the acknowledge lands this cycle.
    assign start_accept = proc_idle && real_start && (!ap_done_reg || ap_continue);

    // Track the pushed start token and the sticky done until acknowledged.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            start_once_reg <= 1'b0;
            ap_done_reg    <= 1'b0;
        end else begin
            if (ap_ready) begin
                start_once_reg <= 1'b0;
            end else if (real_start) begin
                start_once_reg <= 1'b1;
            end
            if (ap_continue) begin
                ap_done_reg <= 1'b0;
            end else if (last_hs) begin
                ap_done_reg <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_sq_pipe.sv
// Pipelined FIFO-to-FIFO squaring stage: reads N_ITER signed words, writes each
// square (MODE_EACH) or one wrapped sum of squares (MODE_SUM).
//
// state | meaning
// IDLE  | waiting for an accepted start; counters and accumulator cleared on exit
// RUN   | streaming reads through the two-stage pipe until the final output write
module stream_sq_pipe
    import stream_sq_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int N_ITER = 5,
    parameter int MODE   = MODE_EACH,
    parameter int CNT_W  = $clog2(N_ITER + 1)
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              ap_start,
    input  logic              start_full_n,
    output logic              ap_done,
    input  logic              ap_continue,
    output logic              ap_idle,
    output logic              ap_ready,
    output logic              start_out,
    output logic              start_write,
    input  logic [DATA_W-1:0] in_dout,
    input  logic              in_empty_n,
    output logic              in_read,
    output logic [DATA_W-1:0] out_din,
    input  logic              out_full_n,
    output logic              out_write
);

    localparam logic [CNT_W-1:0] RD_TOTAL = CNT_W'(N_ITER);
    localparam logic [CNT_W-1:0] WR_LAST  = (MODE == MODE_SUM) ? '0 : CNT_W'(N_ITER - 1);

    state_t            state;
    logic [CNT_W-1:0]  rd_cnt;
    logic [CNT_W-1:0]  wr_cnt;
    logic [DATA_W-1:0] s1_data;
    logic              s1_vld;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] acc_nxt;
    logic [DATA_W-1:0] out_reg;
    logic              out_vld;
    logic [DATA_W-1:0] sq;
    logic              en;
    logic              last_hs;
    logic              real_start;
    logic              start_accept;

    assign en        = !out_vld || out_full_n;
    assign in_read   = (state == RUN) && en && in_empty_n && (rd_cnt < RD_TOTAL);
    assign out_write = out_vld && out_full_n;
    assign last_hs   = out_write && (wr_cnt == WR_LAST);
    // Low DATA_W bits of a product do not depend on operand signedness.
    assign sq        = s1_data * s1_data;
    assign acc_nxt   = acc + sq;
    assign out_din   = out_reg;
    assign start_out = real_start;

    ap_chain_ctl u_ctl (
        .ap_clk       (ap_clk),
        .ap_rst_n     (ap_rst_n),
        .ap_start     (ap_start),
        .start_full_n (start_full_n),
        .ap_continue  (ap_continue),
        .proc_idle    (state == IDLE),
        .last_hs      (last_hs),
        .real_start   (real_start),
        .start_write  (start_write),
        .start_accept (start_accept),
        .ap_done      (ap_done),
        .ap_ready     (ap_ready),
        .ap_idle      (ap_idle)
    );

    // Invocation FSM with read/write element counters.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state  <= IDLE;
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_accept) begin
                        state  <= RUN;
                        rd_cnt <= '0;
                        wr_cnt <= '0;
                    end
                end
                RUN: begin
                    if (in_read) begin
                        rd_cnt <= rd_cnt + 1'b1;
                    end
                    if (out_write) begin
                        wr_cnt <= wr_cnt + 1'b1;
                    end
                    if (last_hs) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Two-stage pipe; every stage advances together whenever the output can drain.
    // While s1 holds a valid word, rd_cnt equals that word's 1-based index.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            s1_data <= '0;
            s1_vld  <= 1'b0;
            acc     <= '0;
            out_reg <= '0;
            out_vld <= 1'b0;
        end else begin
            if (start_accept) begin
                acc <= '0;
            end
            if (en) begin
                s1_vld  <= in_read;
                s1_data <= in_dout;
                if (s1_vld) begin
                    if (MODE == MODE_SUM) begin
                        acc     <= acc_nxt;
                        out_vld <= (rd_cnt == RD_TOTAL);
                        if (rd_cnt == RD_TOTAL) begin
                            out_reg <= acc_nxt;
                        end
                    end else begin
                        out_reg <= sq;
                        out_vld <= 1'b1;
                    end
                end else begin
                    out_vld <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_sq_pipe.sv
// Bench for stream_sq_pipe: one MODE 0 and one MODE 1 instance run in lockstep on
// the same input stream, checked against a queue-based arithmetic reference.
module tb_stream_sq_pipe;

    localparam int DW = 32;
    localparam int NI = 5;

    logic ap_clk = 1'b0;
    logic ap_rst_n = 1'b0;
    logic ap_start = 1'b0;
    logic start_full_n = 1'b1;
    logic ap_continue = 1'b0;
    logic out_full_n = 1'b1;
    logic src_en = 1'b1;

    logic [1:0][DW-1:0] in_dout = '0;
    logic [1:0]         in_empty_n = '0;
    logic [1:0]         ap_done, ap_idle, ap_ready, start_out, start_write, in_read, out_write;
    logic [1:0][DW-1:0] out_din;

    logic [DW-1:0] q0[$], q1[$], got0[$], got1[$], cur_in[$];
    int            rdc0[$], wrc0[$];
    int            rd_n[2], wr_n[2], rdy_n[2], sw_n[2];
    int            cyc = 0;
    int            tests = 0;
    int            fails = 0;

    logic [1:0]         s_in_read, s_out_write, s_done, s_ready, s_idle, s_sw;
    logic [1:0][DW-1:0] s_out_din;

    always #5 ap_clk = ~ap_clk;

    stream_sq_pipe #(.DATA_W(DW), .N_ITER(NI), .MODE(0)) dut_each (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .start_full_n(start_full_n),
        .ap_done(ap_done[0]), .ap_continue(ap_continue), .ap_idle(ap_idle[0]), .ap_ready(ap_ready[0]),
        .start_out(start_out[0]), .start_write(start_write[0]), .in_dout(in_dout[0]),
        .in_empty_n(in_empty_n[0]), .in_read(in_read[0]), .out_din(out_din[0]),
        .out_full_n(out_full_n), .out_write(out_write[0])
    );

    stream_sq_pipe #(.DATA_W(DW), .N_ITER(NI), .MODE(1)) dut_sum (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .start_full_n(start_full_n),
        .ap_done(ap_done[1]), .ap_continue(ap_continue), .ap_idle(ap_idle[1]), .ap_ready(ap_ready[1]),
        .start_out(start_out[1]), .start_write(start_write[1]), .in_dout(in_dout[1]),
        .in_empty_n(in_empty_n[1]), .in_read(in_read[1]), .out_din(out_din[1]),
        .out_full_n(out_full_n), .out_write(out_write[1])
    );

    // Reference: square of a signed word, wrapped to DW bits.
    function automatic logic [DW-1:0] sq_ref(input logic [DW-1:0] x);
        longint v;
        v = longint'($signed(x));
        return DW'(v * v);
    endfunction

    function automatic logic [DW-1:0] sum_ref();
        logic [DW-1:0] s;
        s = '0;
        foreach (cur_in[i]) s = s + sq_ref(cur_in[i]);
        return s;
    endfunction

    task automatic drive();
        in_empty_n[0] = src_en && (q0.size() > 0);
        in_empty_n[1] = src_en && (q1.size() > 0);
        in_dout[0] = 32'hDEAD_BEEF;
        in_dout[1] = 32'hDEAD_BEEF;
        if (q0.size() > 0) in_dout[0] = q0[0];
        if (q1.size() > 0) in_dout[1] = q1[0];
    endtask

    // One clock: drive FIFO view, sample mid-cycle, pop after the edge.
    task automatic step();
        logic [1:0] pop;
        drive();
        @(negedge ap_clk);
        s_in_read = in_read; s_out_write = out_write; s_done = ap_done;
        s_ready = ap_ready; s_idle = ap_idle; s_sw = start_write; s_out_din = out_din;
        pop = in_read;
        if (in_read[0]) begin rd_n[0]++; rdc0.push_back(cyc); end
        if (in_read[1]) rd_n[1]++;
        if (out_write[0]) begin wr_n[0]++; got0.push_back(out_din[0]); wrc0.push_back(cyc); end
        if (out_write[1]) begin wr_n[1]++; got1.push_back(out_din[1]); end
        for (int i = 0; i < 2; i++) begin
            if (ap_ready[i]) rdy_n[i]++;
            if (start_write[i]) sw_n[i]++;
        end
        @(posedge ap_clk);
        #1;
        if (pop[0] && q0.size() > 0) void'(q0.pop_front());
        if (pop[1] && q1.size() > 0) void'(q1.pop_front());
        cyc++;
    endtask

    task automatic clear_obs();
        got0.delete(); got1.delete(); rdc0.delete(); wrc0.delete();
        for (int i = 0; i < 2; i++) begin rd_n[i] = 0; wr_n[i] = 0; rdy_n[i] = 0; sw_n[i] = 0; end
    endtask

    task automatic load(input logic [DW-1:0] v);
        q0.push_back(v); q1.push_back(v); cur_in.push_back(v);
    endtask

    task automatic do_start();
        ap_start = 1'b1;
        step();
        ap_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        do begin step(); n++; end while (!(s_done[0] && s_done[1]) && n < budget);
        tests++;
        if (!(s_done[0] && s_done[1])) begin
            fails++;
            $display("FAIL %s_timeout ap_done=%b after %0d cycles, required 11", name, s_done, n);
        end
    endtask

    task automatic ack();
        ap_continue = 1'b1;
        step();
        ap_continue = 1'b0;
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0;
        ap_start = 1'b0;
        step();
        step();
        tests++;
        if ({s_done, s_ready, s_in_read, s_out_write, s_sw} !== 10'b0) begin
            fails++;
            $display("FAIL reset_ctl done=%b ready=%b rd=%b wr=%b sw=%b, required all 0",
                     s_done, s_ready, s_in_read, s_out_write, s_sw);
        end
        tests++;
        if (s_out_din !== '0) begin
            fails++; $display("FAIL reset_dout got %h required 0", s_out_din);
        end
        tests++;
        if (s_idle !== 2'b11) begin
            fails++; $display("FAIL reset_idle got %b required 11", s_idle);
        end
        ap_start = 1'b1;
        step();
        tests++;
        if (s_idle !== 2'b00) begin
            fails++; $display("FAIL reset_idle_start got %b required 00", s_idle);
        end
        ap_start = 1'b0;
        ap_rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        clear_obs(); cur_in.delete();
        load(32'sd1); load(-32'sd2); load(32'sd3); load(32'sd4); load(-32'sd5);
        do_start();
        wait_done("basic", 50);
        tests++;
        if (got0.size() != NI) begin
            fails++; $display("FAIL basic_count got %0d required %0d", got0.size(), NI);
        end
        foreach (got0[i]) begin
            if (i < cur_in.size()) begin
                tests++;
                if (got0[i] !== sq_ref(cur_in[i])) begin
                    fails++; $display("FAIL basic_sq[%0d] got %0d required %0d", i, got0[i], sq_ref(cur_in[i]));
                end
            end
            if (i < rdc0.size()) begin
                tests++;
                if (wrc0[i] != rdc0[i] + 2 || rdc0[i] != rdc0[0] + i) begin
                    fails++; $display("FAIL basic_lat[%0d] rd@%0d wr@%0d required wr=rd+2, rd=%0d",
                                      i, rdc0[i], wrc0[i], rdc0[0] + i);
                end
            end
        end
        tests++;
        if (got1.size() != 1 || got1[0] !== 32'd55) begin
            fails++; $display("FAIL basic_sum writes=%0d first=%0d required 1 write of 55",
                              got1.size(), (got1.size() > 0) ? got1[0] : 32'd0);
        end
        tests++;
        if (rdy_n[0] != 1 || rdy_n[1] != 1 || sw_n[0] != 1 || sw_n[1] != 1) begin
            fails++; $display("FAIL basic_pulses ready=%0d/%0d start_write=%0d/%0d required 1 each",
                              rdy_n[0], rdy_n[1], sw_n[0], sw_n[1]);
        end
        ack();
    endtask

    task automatic test_overflow();
        logic [DW-1:0] exp_c[5];
        exp_c = '{32'h0, 32'hFFFE_0001, 32'h0, 32'h1, 32'h1};
        clear_obs(); cur_in.delete();
        load(32'h0001_0000); load(32'h0000_FFFF); load(32'h8000_0000); load(32'hFFFF_FFFF); load(32'h7FFF_FFFF);
        do_start();
        wait_done("ovf", 50);
        foreach (got0[i]) begin
            if (i < 5) begin
                tests++;
                if (got0[i] !== exp_c[i]) begin
                    fails++; $display("FAIL ovf_sq[%0d] got %h required %h", i, got0[i], exp_c[i]);
                end
            end
        end
        tests++;
        if (got0.size() != 5 || got1.size() != 1 || got1[0] !== sum_ref()) begin
            fails++; $display("FAIL ovf_sum writes=%0d/%0d sum=%h required 5/1 sum %h", got0.size(),
                              got1.size(), (got1.size() > 0) ? got1[0] : 32'd0, sum_ref());
        end
        ack();
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] held;
        held = '0;
        clear_obs(); cur_in.delete();
        for (int i = 0; i < NI; i++) load($urandom());
        q0.push_back(32'h1234_5678); q1.push_back(32'h1234_5678);
        q0.push_back(32'h9ABC_DEF0); q1.push_back(32'h9ABC_DEF0);
        do_start();
        step(); step(); step();
        out_full_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            tests++;
            if (s_in_read[0] !== 1'b0 || s_out_write[0] !== 1'b0) begin
                fails++; $display("FAIL bp_stall[%0d] in_read=%b out_write=%b required 0/0", k, s_in_read[0], s_out_write[0]);
            end
            tests++;
            if (k == 0) begin
                held = s_out_din[0];
                if (held !== sq_ref(cur_in[got0.size()])) begin
                    fails++; $display("FAIL bp_head got %h required %h", held, sq_ref(cur_in[got0.size()]));
                end
            end else if (s_out_din[0] !== held) begin
                fails++; $display("FAIL bp_hold[%0d] got %h required %h", k, s_out_din[0], held);
            end
        end
        out_full_n = 1'b1;
        wait_done("bp", 60);
        tests++;
        if (got0.size() != NI || rd_n[0] != NI || rd_n[1] != NI) begin
            fails++; $display("FAIL bp_totals writes=%0d reads=%0d/%0d required %0d", got0.size(), rd_n[0], rd_n[1], NI);
        end
        foreach (got0[i]) begin
            if (i < cur_in.size()) begin
                tests++;
                if (got0[i] !== sq_ref(cur_in[i])) begin
                    fails++; $display("FAIL bp_sq[%0d] got %h required %h", i, got0[i], sq_ref(cur_in[i]));
                end
            end
        end
        tests++;
        if (got1.size() != 1 || got1[0] !== sum_ref()) begin
            fails++; $display("FAIL bp_sum writes=%0d required 1 of %h", got1.size(), sum_ref());
        end
        tests++;
        if (q0.size() != 2 || q1.size() != 2) begin
            fails++; $display("FAIL bp_leftover got %0d/%0d words required 2/2", q0.size(), q1.size());
        end
        ack();
        q0.delete(); q1.delete();
    endtask

    task automatic test_chain();
        clear_obs(); cur_in.delete();
        for (int i = 0; i < NI; i++) load($urandom_range(0, 200) - 100);
        do_start();
        wait_done("chain1", 50);
        tests++;
        if (got1.size() != 1 || got1[0] !== sum_ref()) begin
            fails++; $display("FAIL chain1_sum writes=%0d required 1 of %h", got1.size(), sum_ref());
        end
        cur_in.delete();
        for (int i = 0; i < NI; i++) load($urandom());
        ap_start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            tests++;
            if (s_done !== 2'b11 || s_in_read !== 2'b00) begin
                fails++; $display("FAIL chain_block[%0d] done=%b in_read=%b required 11/00", k, s_done, s_in_read);
            end
        end
        clear_obs();
        ap_continue = 1'b1;
        step();
        ap_continue = 1'b0;
        ap_start = 1'b0;
        wait_done("chain2", 50);
        tests++;
        if (got0.size() != NI || got1.size() != 1 || got1[0] !== sum_ref()) begin
            fails++; $display("FAIL chain_b2b writes=%0d/%0d required %0d/1", got0.size(), got1.size(), NI);
        end
        foreach (got0[i]) begin
            if (i < cur_in.size()) begin
                tests++;
                if (got0[i] !== sq_ref(cur_in[i])) begin
                    fails++; $display("FAIL chain_sq[%0d] got %h required %h", i, got0[i], sq_ref(cur_in[i]));
                end
            end
        end
        ack();
        clear_obs(); cur_in.delete();
        for (int i = 0; i < NI; i++) load($urandom());
        start_full_n = 1'b0;
        ap_start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            tests++;
            if (s_sw !== 2'b00 || s_in_read !== 2'b00 || s_idle !== 2'b11) begin
                fails++; $display("FAIL chain_sfull[%0d] start_write=%b in_read=%b idle=%b required 00/00/11",
                                  k, s_sw, s_in_read, s_idle);
            end
        end
        ap_start = 1'b0;
        start_full_n = 1'b1;
        step();
        tests++;
        if (s_in_read !== 2'b00 || rd_n[0] != 0) begin
            fails++; $display("FAIL chain_sfull_idle in_read=%b reads=%0d required 00/0", s_in_read, rd_n[0]);
        end
        do_start();
        wait_done("chain3", 50);
        tests++;
        if (got0.size() != NI || got1.size() != 1 || got1[0] !== sum_ref()) begin
            fails++; $display("FAIL chain3_totals writes=%0d/%0d required %0d/1", got0.size(), got1.size(), NI);
        end
        ack();
    endtask

    task automatic test_random();
        for (int inv = 0; inv < 4; inv++) begin
            clear_obs(); cur_in.delete();
            for (int i = 0; i < NI; i++) load(($urandom_range(0, 1) != 0) ? $urandom() : $urandom_range(0, 64) - 32);
            do_start();
            for (int n = 0; n < 200 && !(s_done[0] && s_done[1]); n++) begin
                src_en = ($urandom_range(0, 9) < 7);
                out_full_n = ($urandom_range(0, 9) < 6);
                step();
            end
            src_en = 1'b1;
            out_full_n = 1'b1;
            wait_done("rand", 50);
            tests++;
            if (got0.size() != NI || rd_n[0] != NI || rd_n[1] != NI || got1.size() != 1) begin
                fails++; $display("FAIL rand%0d_totals writes=%0d/%0d reads=%0d/%0d required %0d/1 %0d/%0d",
                                  inv, got0.size(), got1.size(), rd_n[0], rd_n[1], NI, NI, NI);
            end
            foreach (got0[i]) begin
                if (i < cur_in.size()) begin
                    tests++;
                    if (got0[i] !== sq_ref(cur_in[i])) begin
                        fails++; $display("FAIL rand%0d_sq[%0d] got %h required %h", inv, i, got0[i], sq_ref(cur_in[i]));
                    end
                end
            end
            tests++;
            if (got1.size() > 0 && got1[0] !== sum_ref()) begin
                fails++; $display("FAIL rand%0d_sum got %h required %h", inv, got1[0], sum_ref());
            end
            ack();
        end
    endtask

    task automatic test_reset_midop();
        clear_obs(); cur_in.delete();
        for (int i = 0; i < NI; i++) load($urandom());
        do_start();
        step(); step();
        tests++;
        if (rd_n[0] != 2) begin
            fails++; $display("FAIL rst_mid_reads got %0d required 2", rd_n[0]);
        end
        ap_rst_n = 1'b0;
        #1;
        tests++;
        if ({ap_done, ap_ready, in_read, out_write, start_write} !== 10'b0 || out_din !== '0) begin
            fails++; $display("FAIL rst_mid_outputs done=%b ready=%b rd=%b wr=%b sw=%b dout=%h required all 0",
                              ap_done, ap_ready, in_read, out_write, start_write, out_din);
        end
        q0.delete(); q1.delete();
        step();
        ap_rst_n = 1'b1;
        step();
        clear_obs(); cur_in.delete();
        for (int i = 0; i < NI; i++) load($urandom());
        do_start();
        wait_done("rst_again", 50);
        tests++;
        if (got0.size() != NI || got1.size() != 1 || got1[0] !== sum_ref()) begin
            fails++; $display("FAIL rst_again_totals writes=%0d/%0d required %0d/1", got0.size(), got1.size(), NI);
        end
        foreach (got0[i]) begin
            if (i < cur_in.size()) begin
                tests++;
                if (got0[i] !== sq_ref(cur_in[i])) begin
                    fails++; $display("FAIL rst_again_sq[%0d] got %h required %h", i, got0[i], sq_ref(cur_in[i]));
                end
            end
        end
        ack();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_backpressure();
        test_chain();
        test_random();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

endmodule
